stream_rr_arbiter: RTL and testbench

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 150 +++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Two-requester stream arbiter with round-robin tie breaking and bounded bursts.
// Each grant pops up to BURST head words from one requester and forwards them,
// tagged with their source index, onto a single registered output stream.
//
// Handshake: read_Sn is a pop strobe. It is only ever high while avail_Sn is
// high and afull_S is low, and the word on input_Sn is consumed at that rising
// edge. write_S is a one-cycle strobe, one cycle after the pop. output_S and
// tag_S are valid only while write_S is high. The downstream side can always
// take that single word, even if afull_S has risen in the meantime.
module stream_rr_arbiter #(
    parameter int WIDTH = 16,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_S0,
    input  logic [WIDTH-1:0] input_S1,
    input  logic             avail_S0,
    input  logic             avail_S1,
    output logic             read_S0,
    output logic             read_S1,
    output logic [WIDTH-1:0] output_S,
    output logic             tag_S,
    output logic             write_S,
    input  logic             afull_S,
    output logic             busy,
    output logic [1:0]       dbg_state,
    output logic             dbg_lsp,
    output logic [7:0]       dbg_bcnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_L = 8'(BURST);

    state_t     state;
    state_t     state_nxt;
    logic       lsp;
    logic       lsp_nxt;
    logic [7:0] bcnt;
    logic [7:0] bcnt_nxt;

    logic       g_idx;
    logic       g_avail;
    logic       o_avail;
    logic       rd;

    // Resolve which requester holds the grant and whether it pops this cycle.
    always_comb begin
        g_idx   = (state == GRANT1);
        g_avail = g_idx ? avail_S1 : avail_S0;
        o_avail = g_idx ? avail_S0 : avail_S1;
        rd      = (state != IDLE) && g_avail && !afull_S;
    end

    // State register: grant state, last-served pointer and burst counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            lsp   <= 1'b1;
            bcnt  <= 8'd0;
        end else begin
            state <= state_nxt;
            lsp   <= lsp_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    // Next-state logic.
    // The last read of a burst releases the grant on the same edge. The next
    // owner then reads on the very next cycle. bcnt therefore stays in
    // 0..BURST-1 and cannot wrap.
    always_comb begin
        state_nxt = state;
        lsp_nxt   = lsp;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                bcnt_nxt = 8'd0;
                if (avail_S0 && avail_S1) begin
                    state_nxt = lsp ? GRANT0 : GRANT1;
                end else if (avail_S0) begin
                    state_nxt = GRANT0;
                end else if (avail_S1) begin
                    state_nxt = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // While afull is high, everything freezes.
                if (!afull_S) begin
                    if (!g_avail) begin
                        // The owner ran dry: release now, without a read.
                        lsp_nxt   = g_idx;
                        bcnt_nxt  = 8'd0;
                        if (o_avail) begin
                            state_nxt = g_idx ? GRANT0 : GRANT1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (bcnt >= BURST_L - 8'd1) begin
                        // This read completes the burst.
                        lsp_nxt   = g_idx;
                        bcnt_nxt  = 8'd0;
                        if (o_avail) begin
                            state_nxt = g_idx ? GRANT0 : GRANT1;
                        end else begin
                            state_nxt = state;
                        end
                    end else begin
                        bcnt_nxt = bcnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = 8'd0;
            end
        endcase
    end

    // Output decode: pop strobes, busy flag and debug visibility of the FSM.
    always_comb begin
        read_S0   = rd && !g_idx;
        read_S1   = rd && g_idx;
        busy      = (state != IDLE);
        dbg_state = state;
        dbg_lsp   = lsp;
        dbg_bcnt  = bcnt;
    end

    // Output stage: register the popped word and its source for one-cycle write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            output_S <= '0;
            tag_S    <= 1'b0;
            write_S  <= 1'b0;
        end else begin
            write_S <= rd;
            if (rd) begin
                output_S <= g_idx ? input_S1 : input_S0;
                tag_S    <= g_idx;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter.
// dut4 (BURST=4) runs the directed scenarios and a random run.
// dut1 (BURST=1) runs the long alternation run with random afull.
// Each requester is modelled as a FIFO queue. Expected words and expected tag
// order are queued when the stimulus is issued. The monitor consumes them on
// every write_S.
`timescale 1ns/1ps
module tb_stream_rr_arbiter;

    localparam int W = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_G0   = 2'd1;
    localparam logic [1:0] ST_G1   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Per-instance signals, index 0 = dut4, index 1 = dut1.
    logic [1:0][1:0][W-1:0] data;
    logic [1:0][1:0]        avail;
    logic [1:0]             afull;
    wire  [1:0][1:0]        rd;
    wire  [1:0][W-1:0]      out;
    wire  [1:0]             tag;
    wire  [1:0]             wr;
    wire  [1:0]             busy;
    wire  [1:0][1:0]        dbg_state;
    wire  [1:0]             dbg_lsp;
    wire  [1:0][7:0]        dbg_bcnt;

    stream_rr_arbiter #(.WIDTH(W), .BURST(4)) dut4 (
        .clk(clk), .rst(rst),
        .input_S0(data[0][0]), .input_S1(data[0][1]),
        .avail_S0(avail[0][0]), .avail_S1(avail[0][1]),
        .read_S0(rd[0][0]), .read_S1(rd[0][1]),
        .output_S(out[0]), .tag_S(tag[0]), .write_S(wr[0]),
        .afull_S(afull[0]), .busy(busy[0]),
        .dbg_state(dbg_state[0]), .dbg_lsp(dbg_lsp[0]), .dbg_bcnt(dbg_bcnt[0])
    );

    stream_rr_arbiter #(.WIDTH(W), .BURST(1)) dut1 (
        .clk(clk), .rst(rst),
        .input_S0(data[1][0]), .input_S1(data[1][1]),
        .avail_S0(avail[1][0]), .avail_S1(avail[1][1]),
        .read_S0(rd[1][0]), .read_S1(rd[1][1]),
        .output_S(out[1]), .tag_S(tag[1]), .write_S(wr[1]),
        .afull_S(afull[1]), .busy(busy[1]),
        .dbg_state(dbg_state[1]), .dbg_lsp(dbg_lsp[1]), .dbg_bcnt(dbg_bcnt[1])
    );

    // ---------------- model / scoreboard state ----------------
    logic [W-1:0] src_q [2][2][$];   // words still waiting at each requester
    logic [W-1:0] exp_q [2][2][$];   // words that must still come out, per source
    bit           exp_tag_q [2][$];  // expected tag order (empty = not tracked)
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  wr_cnt [2];
    int  first_wr [2];
    int  last_wr [2];
    bit  gate_rand [2];
    bit  afull_rand [2];
    bit  afull_force [2];
    bit  popped [2][2];

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s @cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    task automatic clear_stats(input int d);
        wr_cnt[d]   = 0;
        first_wr[d] = -1;
        last_wr[d]  = -1;
    endtask

    task automatic load(input int d, input int s, input int n);
        logic [W-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = W'($urandom);
            src_q[d][s].push_back(v);
            exp_q[d][s].push_back(v);
        end
    endtask

    // Monitor: consume one expected word (and tag, if tracked) per write.
    task automatic monitor();
        int           s;
        bit           et;
        logic [W-1:0] e;
        for (int d = 0; d < 2; d++) begin
            if (wr[d]) begin
                s = int'(tag[d]);
                wr_cnt[d]++;
                if (first_wr[d] < 0) first_wr[d] = cyc;
                last_wr[d] = cyc;
                if (exp_tag_q[d].size() > 0) begin
                    et = exp_tag_q[d].pop_front();
                    check(tag[d] == et, $sformatf("dut%0d_tag_order", d), int'(tag[d]), int'(et));
                end
                check(exp_q[d][s].size() > 0, $sformatf("dut%0d_word_expected_src%0d", d, s),
                      int'(out[d]), -1);
                if (exp_q[d][s].size() > 0) begin
                    e = exp_q[d][s].pop_front();
                    check(out[d] == e, $sformatf("dut%0d_data_src%0d", d, s), int'(out[d]), int'(e));
                end
            end
        end
    endtask

    // Driver: requesters present their head word, with optional random gaps.
    task automatic drive();
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 2; s++) begin
                avail[d][s] = (src_q[d][s].size() > 0) &&
                              (!gate_rand[d] || ($urandom_range(0, 3) != 0));
                data[d][s]  = (src_q[d][s].size() > 0) ? src_q[d][s][0] : '0;
            end
            afull[d] = afull_force[d] || (afull_rand[d] && ($urandom_range(0, 2) == 0));
        end
    endtask

    // Just before the rising edge: a pop must be legal; then remove the head word.
    task automatic sample_reads();
        for (int d = 0; d < 2; d++) begin
            if (rd[d] != 2'b00) begin
                check(rd[d] != 2'b11, $sformatf("dut%0d_single_read", d), int'(rd[d]), 1);
            end
            for (int s = 0; s < 2; s++) begin
                popped[d][s] = rd[d][s];
                if (rd[d][s]) begin
                    check(avail[d][s] && !afull[d], $sformatf("dut%0d_read_legal_src%0d", d, s),
                          int'({avail[d][s], afull[d]}), 2);
                    if (src_q[d][s].size() > 0) void'(src_q[d][s].pop_front());
                end
            end
        end
    endtask

    task automatic body();
        cyc++;
        monitor();
        drive();
        #3;
        sample_reads();
    endtask

    task automatic step();
        @(negedge clk);
        body();
    endtask

    task automatic wait_done(input int d, input int budget, input string name);
        int n;
        n = 0;
        while ((src_q[d][0].size() + src_q[d][1].size() + exp_q[d][0].size() +
                exp_q[d][1].size() + exp_tag_q[d].size()) != 0 && n < budget) begin
            step();
            n++;
        end
        check(n < budget, name, n, budget);
    endtask

    task automatic settle(input int d, input string name);
        repeat (3) step();
        check(dbg_state[d] == ST_IDLE, {name, "_idle"}, int'(dbg_state[d]), int'(ST_IDLE));
        check(busy[d] == 1'b0, {name, "_busy"}, int'(busy[d]), 0);
    endtask

    task automatic check_reset_values(input int d, input string name);
        check(out[d] == '0, {name, "_output"}, int'(out[d]), 0);
        check(tag[d] == 1'b0, {name, "_tag"}, int'(tag[d]), 0);
        check(wr[d] == 1'b0, {name, "_write"}, int'(wr[d]), 0);
        check(rd[d] == 2'b00, {name, "_reads"}, int'(rd[d]), 0);
        check(busy[d] == 1'b0, {name, "_busy"}, int'(busy[d]), 0);
        check(dbg_state[d] == ST_IDLE, {name, "_state"}, int'(dbg_state[d]), int'(ST_IDLE));
        check(dbg_lsp[d] == 1'b1, {name, "_lsp"}, int'(dbg_lsp[d]), 1);
        check(dbg_bcnt[d] == 8'd0, {name, "_bcnt"}, int'(dbg_bcnt[d]), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int         wr_before;
        logic [7:0] frz_b;
        logic [1:0] frz_s;
        logic [1:0] prev;
        bit         switched;
        int         n;

        rst   = 1'b0;
        data  = '0;
        avail = '0;
        afull = '0;
        for (int d = 0; d < 2; d++) begin
            gate_rand[d] = 1'b0; afull_rand[d] = 1'b0; afull_force[d] = 1'b0;
            clear_stats(d);
        end

        // Values held while in reset.
        repeat (3) @(negedge clk);
        #1;
        check_reset_values(0, "a_reset_dut4");
        check_reset_values(1, "a_reset_dut1");
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Both requesters busy, BURST=4: bursts of four alternate, starting with S0.
        clear_stats(0);
        load(0, 0, 12);
        load(0, 1, 12);
        for (int k = 0; k < 24; k++) exp_tag_q[0].push_back(((k / 4) % 2) == 1);
        wait_done(0, 200, "b_timeout");
        check(wr_cnt[0] == 24, "b_write_count", wr_cnt[0], 24);
        check(last_wr[0] - first_wr[0] + 1 == 24, "b_no_bubble_span", last_wr[0] - first_wr[0] + 1, 24);
        settle(0, "b");

        // Only S1 has words: ten writes tagged 1, in order, re-granted without a gap.
        clear_stats(0);
        load(0, 1, 10);
        for (int k = 0; k < 10; k++) exp_tag_q[0].push_back(1'b1);
        wait_done(0, 200, "c_timeout");
        check(wr_cnt[0] == 10, "c_write_count", wr_cnt[0], 10);
        check(last_wr[0] - first_wr[0] + 1 == 10, "c_no_bubble_span", last_wr[0] - first_wr[0] + 1, 10);
        settle(0, "c");

        // afull high for five cycles in the middle of an S1 burst.
        clear_stats(0);
        load(0, 0, 12);
        load(0, 1, 12);
        for (int k = 0; k < 24; k++) exp_tag_q[0].push_back(((k / 4) % 2) == 1);
        repeat (7) step();
        afull_force[0] = 1'b1;
        step();
        wr_before = wr_cnt[0];
        frz_b = dbg_bcnt[0];
        frz_s = dbg_state[0];
        check(frz_s == ST_G1, "d_mid_burst_state", int'(frz_s), int'(ST_G1));
        repeat (4) begin
            step();
            check(dbg_bcnt[0] == frz_b, "d_bcnt_frozen", int'(dbg_bcnt[0]), int'(frz_b));
            check(dbg_state[0] == frz_s, "d_state_frozen", int'(dbg_state[0]), int'(frz_s));
        end
        afull_force[0] = 1'b0;
        step();
        check(wr_cnt[0] - wr_before <= 1, "d_writes_during_afull", wr_cnt[0] - wr_before, 1);
        wait_done(0, 200, "d_timeout");
        check(wr_cnt[0] == 24, "d_write_count", wr_cnt[0], 24);
        check(last_wr[0] - first_wr[0] + 1 == 29, "d_span", last_wr[0] - first_wr[0] + 1, 29);
        settle(0, "d");

        // S0 runs dry after two words while S1 waits: immediate hand-over, lsp=0.
        clear_stats(0);
        load(0, 0, 2);
        load(0, 1, 8);
        exp_tag_q[0].push_back(1'b0);
        exp_tag_q[0].push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_tag_q[0].push_back(1'b1);
        prev = dbg_state[0];
        switched = 1'b0;
        n = 0;
        while ((src_q[0][0].size() + src_q[0][1].size() + exp_q[0][0].size() +
                exp_q[0][1].size()) != 0 && n < 100) begin
            step();
            n++;
            if (!switched && prev == ST_G0 && dbg_state[0] == ST_G1) begin
                switched = 1'b1;
                check(dbg_lsp[0] == 1'b0, "e_lsp_after_switch", int'(dbg_lsp[0]), 0);
            end
            prev = dbg_state[0];
        end
        check(n < 100, "e_timeout", n, 100);
        check(switched, "e_direct_switch_to_s1", int'(switched), 1);
        check(wr_cnt[0] == 10, "e_write_count", wr_cnt[0], 10);
        check(last_wr[0] - first_wr[0] + 1 == 11, "e_span", last_wr[0] - first_wr[0] + 1, 11);
        settle(0, "e");

        // Reset pulse during a GRANT1 burst while a write is pending.
        clear_stats(0);
        load(0, 1, 6);
        n = 0;
        while (!popped[0][1] && n < 20) begin
            step();
            n++;
        end
        check(popped[0][1], "f_grant1_read_seen", int'(popped[0][1]), 1);
        @(negedge clk);
        cyc++;
        check(wr[0] == 1'b1, "f_write_pending", int'(wr[0]), 1);
        check(dbg_state[0] == ST_G1, "f_in_grant1", int'(dbg_state[0]), int'(ST_G1));
        rst = 1'b0;
        #1;
        check_reset_values(0, "f_reset");
        // The pending word is discarded by the reset and never reaches downstream.
        if (exp_q[0][1].size() > 0) void'(exp_q[0][1].pop_front());
        load(0, 0, 4);
        for (int k = 0; k < 4; k++) exp_tag_q[0].push_back(1'b0);
        for (int k = 0; k < 5; k++) exp_tag_q[0].push_back(1'b1);
        drive();
        #3;
        sample_reads();
        @(negedge clk);
        rst = 1'b1;
        body();
        wait_done(0, 200, "f_timeout");
        check(wr_cnt[0] == 9, "f_write_count", wr_cnt[0], 9);
        settle(0, "f");

        // BURST=1, both requesters loaded, random afull: strict 0,1,0,1 over 1000 words.
        clear_stats(1);
        afull_rand[1] = 1'b1;
        load(1, 0, 500);
        load(1, 1, 500);
        for (int k = 0; k < 1000; k++) exp_tag_q[1].push_back((k % 2) == 1);
        wait_done(1, 8000, "g_timeout");
        afull_rand[1] = 1'b0;
        check(wr_cnt[1] == 1000, "g_write_count", wr_cnt[1], 1000);
        settle(1, "g");

        // BURST=4 with random availability gaps and random afull.
        clear_stats(0);
        gate_rand[0]  = 1'b1;
        afull_rand[0] = 1'b1;
        load(0, 0, 150);
        load(0, 1, 150);
        wait_done(0, 4000, "h_timeout");
        gate_rand[0]  = 1'b0;
        afull_rand[0] = 1'b0;
        check(wr_cnt[0] == 300, "h_write_count", wr_cnt[0], 300);
        settle(0, "h");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
